// File: rtl/bnn_pkg.sv
// Shared types and sizing for the inference sequencer.
// Holds the sequencer state encoding, default class count, score width and class index width.
package bnn_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned SCORE_W     = 17;
    localparam int unsigned CLASS_W     = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV1  = 3'd1,
        CONV2  = 3'd2,
        FC     = 3'd3,
        ARGMAX = 3'd4,
        OUT    = 3'd5,
        ERR    = 3'd6
    } seq_state_t;

endpackage

// File: rtl/infer_sequencer_if.sv
// Bundles every sequencer signal except clk/rst_n.
//   slave  : sequencer side (drives starts, fc_idx, result, status)
//   master : host/engine side (drives image request, completes, scores, result ready, abort)
interface infer_sequencer_if;

    logic                                      image_in_valid;
    logic                                      image_in_ready;
    logic                                      conv1_start;
    logic                                      conv2_start;
    logic                                      fc_start;
    logic                                      conv1_complete;
    logic                                      conv2_complete;
    logic                                      fc_complete;
    logic        [bnn_pkg::CLASS_W-1:0]        fc_idx;
    logic signed [bnn_pkg::SCORE_W-1:0]        fc_score;
    logic                                      class_out_valid;
    logic                                      class_out_ready;
    logic        [bnn_pkg::CLASS_W-1:0]        class_out;
    logic                                      abort;
    logic                                      busy;
    logic                                      error;

    modport slave (
        input  image_in_valid, conv1_complete, conv2_complete, fc_complete,
               fc_score, class_out_ready, abort,
        output image_in_ready, conv1_start, conv2_start, fc_start,
               fc_idx, class_out_valid, class_out, busy, error
    );

    modport master (
        output image_in_valid, conv1_complete, conv2_complete, fc_complete,
               fc_score, class_out_ready, abort,
        input  image_in_ready, conv1_start, conv2_start, fc_start,
               fc_idx, class_out_valid, class_out, busy, error
    );

endinterface

// File: rtl/argmax_unit.sv
// Running signed argmax over a stream of (idx, score) pairs.
//   clk, rst_n  : clock, async active-low reset
//   clear_i     : synchronous clear of the running best
//   valid_i     : idx_i/score_i carry a score this cycle
//   idx_i       : index of the score; index 0 always seeds the best
//   score_i     : signed score
//   best_idx_o  : winner including the current score (so the caller can
//                 capture the final result in the same cycle as the last score)
module argmax_unit #(
    parameter int unsigned SCORE_W = bnn_pkg::SCORE_W,
    parameter int unsigned IDX_W   = bnn_pkg::CLASS_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic                      valid_i,
    input  logic        [IDX_W-1:0]   idx_i,
    input  logic signed [SCORE_W-1:0] score_i,
    output logic        [IDX_W-1:0]   best_idx_o
);

    logic signed [SCORE_W-1:0] best_q;
    logic        [IDX_W-1:0]   best_idx_q;
    logic                      take_c;

    // Strictly greater keeps the lowest index on ties.
    assign take_c     = valid_i && ((idx_i == '0) || (score_i > best_q));
    assign best_idx_o = take_c ? idx_i : best_idx_q;

    // Best score/index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q     <= '0;
            best_idx_q <= '0;
        end else if (clear_i) begin
            best_q     <= '0;
            best_idx_q <= '0;
        end else if (take_c) begin
            best_q     <= score_i;
            best_idx_q <= idx_i;
        end
    end

endmodule

// File: rtl/infer_sequencer.sv
// Sequences conv1 -> conv2 -> fc engines, then scans the fc scores for the winning class.
//   clk, rst_n : clock, async active-low reset
//   seq_if     : image request, engine start/complete, fc score read,
//                result handshake, abort, busy and sticky error status
module infer_sequencer #(
    parameter int unsigned NUM_CLASSES = bnn_pkg::NUM_CLASSES,
    parameter int unsigned SCORE_W     = bnn_pkg::SCORE_W,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    infer_sequencer_if.slave    seq_if
);

    import bnn_pkg::*;

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 16) ? $clog2(TIMEOUT_CYC) : 4;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ARG_LAST = CNT_W'(NUM_CLASSES - 1);

    seq_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 conv1_start_q, conv1_start_d;
    logic                 conv2_start_q, conv2_start_d;
    logic                 fc_start_q, fc_start_d;
    logic                 class_out_valid_q, class_out_valid_d;
    logic [CLASS_W-1:0]   class_out_q, class_out_d;
    logic                 image_in_ready_q, image_in_ready_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;
    logic [CLASS_W-1:0]   best_idx_c;
    logic                 scan_c;

    assign scan_c        = (state_q == ARGMAX);
    assign seq_if.fc_idx = scan_c ? CLASS_W'(cnt_q) : '0;

    argmax_unit #(
        .SCORE_W (SCORE_W),
        .IDX_W   (CLASS_W)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (seq_if.abort),
        .valid_i    (scan_c),
        .idx_i      (seq_if.fc_idx),
        .score_i    (SCORE_W'(seq_if.fc_score)),
        .best_idx_o (best_idx_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        class_out_d = class_out_q;

        case (state_q)
            IDLE:   if (seq_if.image_in_valid && image_in_ready_q) state_d = CONV1;
            // cnt_q == 0 is the start cycle, where complete is not trusted
            CONV1:  if (seq_if.conv1_complete && (cnt_q != '0)) state_d = CONV2;
                    else if (cnt_q == TO_LAST)                    state_d = ERR;
            CONV2:  if (seq_if.conv2_complete && (cnt_q != '0)) state_d = FC;
                    else if (cnt_q == TO_LAST)                    state_d = ERR;
            FC:     if (seq_if.fc_complete && (cnt_q != '0))    state_d = ARGMAX;
                    else if (cnt_q == TO_LAST)                    state_d = ERR;
            ARGMAX: if (cnt_q == ARG_LAST) begin
                        state_d     = OUT;
                        class_out_d = best_idx_c;
                    end
            OUT:    if (seq_if.class_out_ready) state_d = IDLE;
            ERR:    state_d = ERR;
            default: state_d = IDLE;
        endcase

        // Abort overrides any handshake or completion seen this cycle
        if (seq_if.abort) begin
            state_d     = IDLE;
            class_out_d = class_out_q;
        end

        // Counter restarts at 0 on every state change
        cnt_d = (state_d == state_q) ? (cnt_q + CNT_W'(1)) : '0;

        conv1_start_d     = (state_d == CONV1) && (state_q != CONV1);
        conv2_start_d     = (state_d == CONV2) && (state_q != CONV2);
        fc_start_d        = (state_d == FC)    && (state_q != FC);
        class_out_valid_d = (state_d == OUT);
        image_in_ready_d  = (state_d == IDLE);
        busy_d            = (state_d != IDLE);
        error_d           = (state_d == ERR);
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            conv1_start_q     <= 1'b0;
            conv2_start_q     <= 1'b0;
            fc_start_q        <= 1'b0;
            class_out_valid_q <= 1'b0;
            class_out_q       <= '0;
            image_in_ready_q  <= 1'b1;
            busy_q            <= 1'b0;
            error_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            conv1_start_q     <= conv1_start_d;
            conv2_start_q     <= conv2_start_d;
            fc_start_q        <= fc_start_d;
            class_out_valid_q <= class_out_valid_d;
            class_out_q       <= class_out_d;
            image_in_ready_q  <= image_in_ready_d;
            busy_q            <= busy_d;
            error_q           <= error_d;
        end
    end

    assign seq_if.conv1_start     = conv1_start_q;
    assign seq_if.conv2_start     = conv2_start_q;
    assign seq_if.fc_start        = fc_start_q;
    assign seq_if.class_out_valid = class_out_valid_q;
    assign seq_if.class_out       = class_out_q;
    assign seq_if.image_in_ready  = image_in_ready_q;
    assign seq_if.busy            = busy_q;
    assign seq_if.error           = error_q;

endmodule

// File: tb/tb_infer_sequencer.sv
// Scoreboard bench for infer_sequencer: stimulus pushes the expected class,
// latency and valid-hold length; a monitor pops and checks on each result.
module tb_infer_sequencer;

    localparam int NC      = 10;
    localparam int TIMEOUT = 4096;

    typedef struct {
        int cls;
        int lat;
        int hold;
        int hs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_cfg [3];
    int   c_cnt [3];
    exp_t sb_q [$];
    logic signed [16:0] scores [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    infer_sequencer_if sif ();

    infer_sequencer #(
        .NUM_CLASSES (NC),
        .SCORE_W     (17),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (sif)
    );

    // Score buffer answers the read index combinationally
    assign sif.fc_score = scores[sif.fc_idx];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: first index holding the maximum signed score
    function automatic int model_argmax();
        int best = 0;
        for (int i = 1; i < NC; i++)
            if (scores[i] > scores[best]) best = i;
        return best;
    endfunction

    // Start pulse counters
    always @(negedge clk) begin
        if (sif.conv1_start) c_cnt[0]++;
        if (sif.conv2_start) c_cnt[1]++;
        if (sif.fc_start)    c_cnt[2]++;
    end

    // Engine models: complete pulses n cycles after start (n = 0 means never)
    initial begin
        sif.conv1_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (sif.conv1_start && n_cfg[0] > 0) begin
                repeat (n_cfg[0]) @(negedge clk);
                sif.conv1_complete = 1'b1;
                @(negedge clk);
                sif.conv1_complete = 1'b0;
            end
        end
    end
    initial begin
        sif.conv2_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (sif.conv2_start && n_cfg[1] > 0) begin
                repeat (n_cfg[1]) @(negedge clk);
                sif.conv2_complete = 1'b1;
                @(negedge clk);
                sif.conv2_complete = 1'b0;
            end
        end
    end
    initial begin
        sif.fc_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (sif.fc_start && n_cfg[2] > 0) begin
                repeat (n_cfg[2]) @(negedge clk);
                sif.fc_complete = 1'b1;
                @(negedge clk);
                sif.fc_complete = 1'b0;
            end
        end
    end

    // Monitor: pops an expectation at each result and tracks its hold
    exp_t cur;
    bit   in_out = 1'b0;
    int   held = 0;
    int   held_cls = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (sif.class_out_valid) begin
                if (!in_out) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                        cur = '{cls: -1, lat: -1, hold: -1, hs: 0};
                    end else begin
                        cur = sb_q.pop_front();
                        check("class_out", int'(sif.class_out), cur.cls);
                        check("latency", cyc - cur.hs, cur.lat);
                    end
                    in_out   = 1'b1;
                    held     = 1;
                    held_cls = int'(sif.class_out);
                end else begin
                    held++;
                    check("class_stable", int'(sif.class_out), held_cls);
                end
            end else if (in_out) begin
                in_out = 1'b0;
                check("valid_hold", held, cur.hold);
                check("class_hold_after", int'(sif.class_out), held_cls);
            end
        end
    end

    task automatic handshake(output int hs);
        int w = 0;
        @(negedge clk);
        while (!sif.image_in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("hs_ready", int'(sif.image_in_ready), 1);
        sif.image_in_valid = 1'b1;
        hs = cyc;
        @(negedge clk);
        sif.image_in_valid = 1'b0;
    endtask

    task automatic run_inf(input int a, input int b, input int c, input int rd);
        int hs;
        int w = 0;
        int base [3];
        exp_t e;
        base = c_cnt;
        n_cfg[0] = a; n_cfg[1] = b; n_cfg[2] = c;
        e.cls  = model_argmax();
        e.lat  = 1 + (a + 1) + (b + 1) + (c + 1) + NC;
        e.hold = rd + 1;
        handshake(hs);
        e.hs = hs;
        sb_q.push_back(e);
        while (!sif.class_out_valid && w < e.lat + 50) begin
            @(negedge clk);
            w++;
        end
        check("valid_seen", int'(sif.class_out_valid), 1);
        repeat (rd) @(negedge clk);
        sif.class_out_ready = 1'b1;
        @(negedge clk);
        sif.class_out_ready = 1'b0;
        check("idle_valid", int'(sif.class_out_valid), 0);
        check("idle_ready", int'(sif.image_in_ready), 1);
        check("conv1_starts", c_cnt[0] - base[0], 1);
        check("conv2_starts", c_cnt[1] - base[1], 1);
        check("fc_starts",    c_cnt[2] - base[2], 1);
    endtask

    task automatic rand_scores();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 0)
                scores[i] = 17'(int'($urandom_range(0, 4)) - 2);
            else
                scores[i] = 17'(int'($urandom_range(0, 131071)) - 65536);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int w;
        int t0;
        int base [3];
        rst_n = 1'b0;
        sif.image_in_valid  = 1'b0;
        sif.class_out_ready = 1'b0;
        sif.abort           = 1'b0;
        n_cfg = '{1, 1, 1};
        c_cnt = '{0, 0, 0};
        for (int i = 0; i < 16; i++) scores[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", int'(sif.image_in_ready), 1);
        check("rst_busy",  int'(sif.busy), 0);
        check("rst_error", int'(sif.error), 0);
        check("rst_valid", int'(sif.class_out_valid), 0);
        check("rst_class", int'(sif.class_out), 0);
        check("rst_fc_idx", int'(sif.fc_idx), 0);
        check("rst_starts", int'(sif.conv1_start) + int'(sif.conv2_start) + int'(sif.fc_start), 0);
        rst_n = 1'b1;

        // Reference example: tie at 9 resolves to index 2
        scores[0] = 17'sd5; scores[1] = -17'sd3; scores[2] = 17'sd9; scores[3] = 17'sd9;
        run_inf(3, 5, 2, 0);
        check("example_class", int'(sif.class_out), 2);

        for (int i = 0; i < 16; i++) scores[i] = -17'sd65536;
        run_inf(1, 1, 1, 0);

        rand_scores();
        for (int i = 0; i < 9; i++) if (scores[i] == 17'sd65535) scores[i] = '0;
        scores[9] = 17'sd65535;
        run_inf(2, 4, 1, 1);

        rand_scores();
        run_inf(2, 2, 2, 20);

        for (int t = 0; t < 20; t++) begin
            rand_scores();
            run_inf(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)),
                    int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
        end

        // Abort coincident with image handshake
        @(negedge clk);
        base = c_cnt;
        sif.image_in_valid = 1'b1;
        sif.abort          = 1'b1;
        @(negedge clk);
        sif.image_in_valid = 1'b0;
        sif.abort          = 1'b0;
        check("abort_hs_busy", int'(sif.busy), 0);
        @(negedge clk);
        check("abort_hs_conv1", c_cnt[0] - base[0], 0);

        // Abort coincident with conv1_complete
        base = c_cnt;
        n_cfg = '{3, 2, 2};
        handshake(hs);
        w = 0;
        while (!sif.conv1_start && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        check("abort_cpl_ready", int'(sif.image_in_ready), 1);
        check("abort_cpl_c2start", int'(sif.conv2_start), 0);
        repeat (10) @(negedge clk);
        check("abort_cpl_conv1", c_cnt[0] - base[0], 1);
        check("abort_cpl_conv2", c_cnt[1] - base[1], 0);
        check("abort_cpl_fc", c_cnt[2] - base[2], 0);

        // conv2 never completes: timeout to ERR, then abort clears
        n_cfg = '{3, 0, 2};
        handshake(hs);
        w = 0;
        while (!sif.conv2_start && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("to_conv2_start", int'(sif.conv2_start), 1);
        t0 = cyc;
        w = 0;
        while (!sif.error && w < TIMEOUT + 100) begin
            @(negedge clk);
            w++;
        end
        check("to_cycles", cyc - t0, TIMEOUT);
        check("to_error", int'(sif.error), 1);
        repeat (5) @(negedge clk);
        check("to_sticky", int'(sif.error), 1);
        check("to_busy", int'(sif.busy), 1);
        check("to_ready", int'(sif.image_in_ready), 0);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        check("to_abort_ready", int'(sif.image_in_ready), 1);
        check("to_abort_error", int'(sif.error), 0);
        check("to_abort_busy", int'(sif.busy), 0);

        // Reset during FC abandons the inference
        n_cfg = '{2, 2, 0};
        handshake(hs);
        w = 0;
        while (!sif.fc_start && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("rst_fc_start", int'(sif.fc_start), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", int'(sif.image_in_ready), 1);
        check("rst_mid_busy", int'(sif.busy), 0);
        check("rst_mid_class", int'(sif.class_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = c_cnt;
        repeat (30) @(negedge clk);
        check("rst_rel_starts", (c_cnt[0] - base[0]) + (c_cnt[1] - base[1]) + (c_cnt[2] - base[2]), 0);
        check("rst_rel_valid", int'(sif.class_out_valid), 0);
        check("rst_rel_ready", int'(sif.image_in_ready), 1);

        // Recovery
        rand_scores();
        run_inf(1, 2, 3, 2);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
